// File: rtl/subpix_avg.sv
// subpix_avg: averages 2^shift_bit valid subpixel samples per window within an active line.
// Optional build macro SUBPIX_AVG_ROUND_EN selects round-half-up instead of truncation.
module subpix_avg #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic              i_de,
  input  logic [DATA_W-1:0] i_pix,
  input  logic [3:0]        shift_bit,
  output logic [DATA_W-1:0] o_pix,
  output logic              o_valid,
  output logic              o_err
);
  logic [6:0]        count;
  logic [ACC_W-1:0]  acc, sum, rnd;
  logic [3:0]        win_shift;
  logic              active, last;
  logic [DATA_W-1:0] avg;
  always_comb begin
    active = i_hs && i_vs;
    sum    = acc + ACC_W'(i_pix);
    last   = count == ~(7'h7f << win_shift);
`ifdef SUBPIX_AVG_ROUND_EN
    rnd    = (win_shift == 4'd0) ? '0 : ACC_W'(1) << (win_shift - 4'd1);
`else
    rnd    = '0;
`endif
    avg    = DATA_W'((sum + rnd) >> win_shift);
  end
  // count == 0 is IDLE; pass-through (8) and N = 1 windows never leave it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      acc       <= '0;
      win_shift <= '0;
      o_pix     <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
    end else if (!active) begin
      count     <= '0;
      acc       <= '0;
      win_shift <= '0;
      o_pix     <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (i_de) begin
        if (count == 7'd0) begin
          win_shift <= shift_bit;
          if (shift_bit[3] || shift_bit == 4'd0) begin
            o_pix   <= i_pix;
            o_valid <= 1'b1;
            o_err   <= shift_bit[3];
          end else begin
            acc   <= ACC_W'(i_pix);
            count <= 7'd1;
          end
        end else if (last) begin
          o_pix   <= avg;
          o_valid <= 1'b1;
          acc     <= '0;
          count   <= '0;
        end else begin
          acc   <= sum;
          count <= count + 7'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_subpix_avg.sv
// tb_subpix_avg: directed checks of subpix_avg windows, blanking, pass-through and reset.
module tb_subpix_avg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_hs = 1'b1, i_vs = 1'b1, i_de = 1'b0;
  logic [7:0] i_pix = '0;
  logic [3:0] shift_bit = '0;
  logic [7:0] o_pix;
  logic       o_valid, o_err;
  int         vectors = 0, errors = 0;

  subpix_avg dut (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_pix(i_pix), .shift_bit(shift_bit), .o_pix(o_pix), .o_valid(o_valid), .o_err(o_err)
  );

  always #5 clk = ~clk;

`ifdef SUBPIX_AVG_ROUND_EN
  localparam logic [7:0] EXP_S1 = 8'd4;
`else
  localparam logic [7:0] EXP_S1 = 8'd3;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic de, input logic [7:0] pix, input logic [3:0] sb);
    i_de = de; i_pix = pix; shift_bit = sb;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic e, input logic [7:0] p);
    check({tag, ".valid"}, 32'(o_valid), 32'(v));
    check({tag, ".err"}, 32'(o_err), 32'(e));
    check({tag, ".pix"}, 32'(o_pix), 32'(p));
  endtask

  initial begin
    int n;
    logic de;
    #2;
    chk_out("reset", 1'b0, 1'b0, 8'd0);
    check("reset.count", 32'(dut.count), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // N = 1 output gives o_pix a nonzero value before the reset test
    drive(1'b1, 8'd99, 4'd0);
    chk_out("n1", 1'b1, 1'b0, 8'd99);
    drive(1'b1, 8'd1, 4'd3);
    drive(1'b1, 8'd2, 4'd3);
    drive(1'b1, 8'd3, 4'd3);
    check("mid.count", 32'(dut.count), 32'd3);
    check("mid.pix_held", 32'(o_pix), 32'd99);
    i_de = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 8'd0);
    check("async_rst.count", 32'(dut.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    drive(1'b1, 8'd10, 4'd2);
    chk_out("s2.a", 1'b0, 1'b0, 8'd0);
    drive(1'b1, 8'd20, 4'd2);
    drive(1'b1, 8'd30, 4'd2);
    chk_out("s2.c", 1'b0, 1'b0, 8'd0);
    drive(1'b1, 8'd41, 4'd2);
    chk_out("s2.out", 1'b1, 1'b0, 8'd25);
    drive(1'b0, 8'd0, 4'd2);
    chk_out("s2.idle", 1'b0, 1'b0, 8'd25);

    drive(1'b1, 8'd3, 4'd1);
    check("s1.a.valid", 32'(o_valid), 32'd0);
    drive(1'b1, 8'd4, 4'd1);
    chk_out("s1.out", 1'b1, 1'b0, EXP_S1);
    drive(1'b1, 8'd5, 4'd1);
    check("b2b.a.valid", 32'(o_valid), 32'd0);
    drive(1'b1, 8'd7, 4'd1);
    chk_out("b2b.out", 1'b1, 1'b0, 8'd6);

    // shift_bit drops to 2 after the first sample; the window keeps N = 128
    n = 0;
    for (int c = 0; n < 128; c++) begin
      de = (c % 3) != 2;
      drive(de, 8'd255, (n == 0) ? 4'd7 : 4'd2);
      if (de) n++;
      check("s7.valid", 32'(o_valid), 32'(de && n == 128));
    end
    chk_out("s7.out", 1'b1, 1'b0, 8'd255);

    drive(1'b1, 8'd7, 4'd8);
    chk_out("pt.a", 1'b1, 1'b1, 8'd7);
    drive(1'b1, 8'd9, 4'd8);
    chk_out("pt.b", 1'b1, 1'b1, 8'd9);
    drive(1'b0, 8'd0, 4'd8);
    chk_out("pt.idle", 1'b0, 1'b0, 8'd9);

    for (int k = 0; k < 5; k++) drive(1'b1, 8'd50, 4'd3);
    check("part.count", 32'(dut.count), 32'd5);
    i_hs = 1'b0;
    drive(1'b1, 8'd50, 4'd3);
    chk_out("blank", 1'b0, 1'b0, 8'd0);
    check("blank.count", 32'(dut.count), 32'd0);
    i_hs = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 8'd16, 4'd3);
      check("line2.valid", 32'(o_valid), 32'd0);
    end
    drive(1'b1, 8'd16, 4'd3);
    chk_out("line2.out", 1'b1, 1'b0, 8'd16);

    drive(1'b1, 8'd40, 4'd1);
    i_vs = 1'b0;
    drive(1'b1, 8'd40, 4'd1);
    chk_out("lastblank", 1'b0, 1'b0, 8'd0);
    i_vs = 1'b1;
    drive(1'b1, 8'd77, 4'd0);
    chk_out("after_blank_n1", 1'b1, 1'b0, 8'd77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
